// File: rtl/console_io_bridge_pkg.sv
// Shared definitions for the console bridge: RX capture FSM states and
// error-flag bit positions.
package console_io_bridge_pkg;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_ACK      = 2'd1,
        RX_WAIT_LOW = 2'd2
    } rx_state_t;

    localparam int ERR_TX_OVF = 0;
    localparam int ERR_RX_UDF = 1;

endpackage

// File: rtl/console_io_bridge_sync_fifo.sv
// Synchronous first-word fall-through FIFO with modulo-depth pointers and an
// explicit occupancy counter; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so the outputs are clean after reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/console_io_bridge.sv
// Buffered console channel: TX/RX FIFOs between the core's console registers
// and the console pins, a 4-phase capture FSM for input and sticky error flags.
module console_io_bridge
    import console_io_bridge_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OUT_DEPTH = 16,
    parameter int IN_DEPTH  = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic                         out_full,
    output logic                         in_empty,
    output logic [1:0]                   err_flags,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            CONSOLE_OUT,
    output logic                         CONSOLE_OUT_valid,
    input  logic                         CONSOLE_OUT_ready,
    input  logic [DATA_W-1:0]            CONSOLE_IN,
    input  logic                         CONSOLE_IN_valid,
    output logic                         CONSOLE_IN_ack
);

    logic      tx_empty;
    logic      tx_pop;
    logic      rx_full;
    logic      rx_pop;
    logic      capture;
    logic [1:0] err_set;
    rx_state_t state_q;
    rx_state_t state_d;

    assign CONSOLE_OUT_valid = !tx_empty;
    assign tx_pop            = CONSOLE_OUT_valid && CONSOLE_OUT_ready;
    assign rx_pop            = rd_en && !in_empty;
    assign CONSOLE_IN_ack    = (state_q == RX_ACK);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_tx_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (tx_pop),
        .head      (CONSOLE_OUT),
        .count     (out_count),
        .full      (out_full),
        .empty     (tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_rx_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (capture),
        .push_data (CONSOLE_IN),
        .pop       (rx_pop),
        .head      (rd_data),
        .count     (in_count),
        .full      (rx_full),
        .empty     (in_empty)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    // A held request is captured once; WAIT_LOW blocks re-capture until valid drops.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (CONSOLE_IN_valid && (!rx_full || rx_pop)) begin
                    capture = 1'b1;
                    state_d = RX_ACK;
                end
            end
            RX_ACK:      state_d = RX_WAIT_LOW;
            RX_WAIT_LOW: if (!CONSOLE_IN_valid) state_d = RX_IDLE;
            default:     state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        err_set             = 2'b00;
        err_set[ERR_TX_OVF] = wr_en && out_full && !tx_pop;
        err_set[ERR_RX_UDF] = rd_en && in_empty;
    end

    // A new error in the same cycle as err_clr wins over the clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_flags <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (err_set[i])   err_flags[i] <= 1'b1;
                else if (err_clr) err_flags[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_console_io_bridge.sv
// Directed self-checking bench for console_io_bridge with hand-computed
// expected values, one task per scenario.
module tb_console_io_bridge;

    logic       CLK;
    logic       RESET;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic [4:0] out_count;
    logic [4:0] in_count;
    logic       out_full;
    logic       in_empty;
    logic [1:0] err_flags;
    logic       err_clr;
    logic [7:0] CONSOLE_OUT;
    logic       CONSOLE_OUT_valid;
    logic       CONSOLE_OUT_ready;
    logic [7:0] CONSOLE_IN;
    logic       CONSOLE_IN_valid;
    logic       CONSOLE_IN_ack;

    int tests_run;
    int tests_failed;

    console_io_bridge #(.DATA_W(8), .OUT_DEPTH(16), .IN_DEPTH(16)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .out_count         (out_count),
        .in_count          (in_count),
        .out_full          (out_full),
        .in_empty          (in_empty),
        .err_flags         (err_flags),
        .err_clr           (err_clr),
        .CONSOLE_OUT       (CONSOLE_OUT),
        .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
        .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
        .CONSOLE_IN        (CONSOLE_IN),
        .CONSOLE_IN_valid  (CONSOLE_IN_valid),
        .CONSOLE_IN_ack    (CONSOLE_IN_ack)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        wr_en = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h12; tick();
        wr_data = 8'h13; tick();
        wr_en = 1'b0;
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        tests_run++;
        if (out_count !== 5'd3) begin tests_failed++; $display("[TB] FAIL pre_reset_count got %0d exp 3", out_count); end
        tests_run++;
        if (err_flags !== 2'b10) begin tests_failed++; $display("[TB] FAIL pre_reset_udf got %b exp 10", err_flags); end
        #2 RESET = 1'b1;
        #1;
        tests_run++;
        if (out_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_out_count got %0d exp 0", out_count); end
        tests_run++;
        if (CONSOLE_OUT_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b exp 0", CONSOLE_OUT_valid); end
        tests_run++;
        if (CONSOLE_OUT !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_out_data got %h exp 00", CONSOLE_OUT); end
        tests_run++;
        if (err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_err got %b exp 00", err_flags); end
        tests_run++;
        if (CONSOLE_IN_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ack got %b exp 0", CONSOLE_IN_ack); end
        tests_run++;
        if (in_empty !== 1'b1 || rd_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rx got empty=%b data=%h exp 1/00", in_empty, rd_data); end
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_tx_order();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        CONSOLE_OUT_ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = exp[i];
            tick();
        end
        wr_en = 1'b0;
        tick();
        tests_run++;
        if (CONSOLE_OUT_valid !== 1'b1 || CONSOLE_OUT !== 8'h41) begin tests_failed++; $display("[TB] FAIL tx_hold got valid=%b data=%h exp 1/41", CONSOLE_OUT_valid, CONSOLE_OUT); end
        tests_run++;
        if (out_count !== 5'd3) begin tests_failed++; $display("[TB] FAIL tx_count got %0d exp 3", out_count); end
        CONSOLE_OUT_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (CONSOLE_OUT_valid !== 1'b1 || CONSOLE_OUT !== exp[i]) begin tests_failed++; $display("[TB] FAIL tx_order[%0d] got valid=%b data=%h exp 1/%h", i, CONSOLE_OUT_valid, CONSOLE_OUT, exp[i]); end
            tick();
        end
        CONSOLE_OUT_ready = 1'b0;
        tests_run++;
        if (CONSOLE_OUT_valid !== 1'b0 || out_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL tx_drained got valid=%b count=%0d exp 0/0", CONSOLE_OUT_valid, out_count); end
    endtask

    task automatic test_tx_overflow();
        CONSOLE_OUT_ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tests_run++;
        if (out_full !== 1'b1 || out_count !== 5'd16) begin tests_failed++; $display("[TB] FAIL ovf_full got full=%b count=%0d exp 1/16", out_full, out_count); end
        tests_run++;
        if (err_flags[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_flag got %b exp 1", err_flags[0]); end
        err_clr = 1'b1; tick();
        err_clr = 1'b0;
        tests_run++;
        if (err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL ovf_clear got %b exp 00", err_flags); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [16];
        for (int i = 0; i < 14; i++) exp[i] = 8'h62 + 8'(i);
        exp[14] = 8'h80;
        exp[15] = 8'h81;
        CONSOLE_OUT_ready = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h80; tick();
        tests_run++;
        if (out_count !== 5'd16 || CONSOLE_OUT !== 8'h61 || err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL b2b_first got count=%0d data=%h err=%b exp 16/61/00", out_count, CONSOLE_OUT, err_flags); end
        wr_data = 8'h81; tick();
        tests_run++;
        if (out_count !== 5'd16 || CONSOLE_OUT !== 8'h62 || err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL b2b_second got count=%0d data=%h err=%b exp 16/62/00", out_count, CONSOLE_OUT, err_flags); end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (CONSOLE_OUT_valid !== 1'b1 || CONSOLE_OUT !== exp[i]) begin tests_failed++; $display("[TB] FAIL b2b_drain[%0d] got valid=%b data=%h exp 1/%h", i, CONSOLE_OUT_valid, CONSOLE_OUT, exp[i]); end
            tick();
        end
        CONSOLE_OUT_ready = 1'b0;
        tests_run++;
        if (CONSOLE_OUT_valid !== 1'b0 || out_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL b2b_empty got valid=%b count=%0d exp 0/0", CONSOLE_OUT_valid, out_count); end
    endtask

    task automatic test_rx_capture();
        int ack_cnt;
        ack_cnt = 0;
        CONSOLE_IN = 8'h5A;
        CONSOLE_IN_valid = 1'b1;
        tick();
        tests_run++;
        if (CONSOLE_IN_ack !== 1'b1 || in_count !== 5'd1) begin tests_failed++; $display("[TB] FAIL rx_ack_rise got ack=%b count=%0d exp 1/1", CONSOLE_IN_ack, in_count); end
        tick();
        tests_run++;
        if (CONSOLE_IN_ack !== 1'b0) begin tests_failed++; $display("[TB] FAIL rx_ack_fall got %b exp 0", CONSOLE_IN_ack); end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (CONSOLE_IN_ack === 1'b1) ack_cnt++;
        end
        tests_run++;
        if (ack_cnt !== 0 || in_count !== 5'd1) begin tests_failed++; $display("[TB] FAIL rx_single got extra_acks=%0d count=%0d exp 0/1", ack_cnt, in_count); end
        tests_run++;
        if (rd_data !== 8'h5A || in_empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL rx_head got data=%h empty=%b exp 5a/0", rd_data, in_empty); end
        CONSOLE_IN_valid = 1'b0; tick();
        CONSOLE_IN = 8'h5B;
        CONSOLE_IN_valid = 1'b1; tick();
        tests_run++;
        if (CONSOLE_IN_ack !== 1'b1 || in_count !== 5'd2) begin tests_failed++; $display("[TB] FAIL rx_second got ack=%b count=%0d exp 1/2", CONSOLE_IN_ack, in_count); end
        CONSOLE_IN_valid = 1'b0; tick();
        rd_en = 1'b1; tick();
        tests_run++;
        if (rd_data !== 8'h5B || in_count !== 5'd1) begin tests_failed++; $display("[TB] FAIL rx_pop1 got data=%h count=%0d exp 5b/1", rd_data, in_count); end
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (in_empty !== 1'b1 || rd_data !== 8'h00 || err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL rx_pop2 got empty=%b data=%h err=%b exp 1/00/00", in_empty, rd_data, err_flags); end
    endtask

    task automatic test_rx_backpressure();
        logic [7:0] exp [16];
        for (int i = 0; i < 15; i++) exp[i] = 8'h21 + 8'(i);
        exp[15] = 8'h33;
        for (int i = 0; i < 16; i++) begin
            CONSOLE_IN = 8'h20 + 8'(i);
            CONSOLE_IN_valid = 1'b1; tick();
            CONSOLE_IN_valid = 1'b0; tick();
            tick();
        end
        tests_run++;
        if (in_count !== 5'd16) begin tests_failed++; $display("[TB] FAIL rx_fill got %0d exp 16", in_count); end
        CONSOLE_IN = 8'h33;
        CONSOLE_IN_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (CONSOLE_IN_ack !== 1'b0 || in_count !== 5'd16) begin tests_failed++; $display("[TB] FAIL rx_stall[%0d] got ack=%b count=%0d exp 0/16", i, CONSOLE_IN_ack, in_count); end
        end
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        tests_run++;
        if (CONSOLE_IN_ack !== 1'b1 || in_count !== 5'd16 || rd_data !== 8'h21) begin tests_failed++; $display("[TB] FAIL rx_release got ack=%b count=%0d data=%h exp 1/16/21", CONSOLE_IN_ack, in_count, rd_data); end
        CONSOLE_IN_valid = 1'b0; tick();
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if (rd_data !== exp[i]) begin tests_failed++; $display("[TB] FAIL rx_drain[%0d] got %h exp %h", i, rd_data, exp[i]); end
            tick();
        end
        rd_en = 1'b0;
        tests_run++;
        if (in_empty !== 1'b1 || err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL rx_final got empty=%b err=%b exp 1/00", in_empty, err_flags); end
        err_clr = 1'b1;
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        tests_run++;
        if (err_flags !== 2'b10) begin tests_failed++; $display("[TB] FAIL err_set_priority got %b exp 10", err_flags); end
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (err_flags !== 2'b00) begin tests_failed++; $display("[TB] FAIL err_clear got %b exp 00", err_flags); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        RESET = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        rd_en = 1'b0;
        err_clr = 1'b0;
        CONSOLE_OUT_ready = 1'b0;
        CONSOLE_IN = 8'h00;
        CONSOLE_IN_valid = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_back_to_back();
        test_rx_capture();
        test_rx_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
